// File: rtl/conv3x3_mac.sv
// conv3x3_mac: serial 3x3 convolution multiply-accumulate.
// Takes one unsigned window element per valid cycle and multiplies it by a
// programmable signed kernel weight. After the ninth element it emits one
// signed result, together with a one-cycle acc_valid pulse.
// Optional build macro CONV_RELU_EN: when defined, a negative result is
// clamped to zero before it is registered into acc_out.
//
// state | meaning
// IDLE  | waiting for win_start; elements without win_start are dropped
// ACC   | window partially accumulated; cnt is the index of the next element
module conv3x3_mac #(
    parameter int DATA_W = 8,
    parameter int W_W    = 8,
    parameter int KSIZE  = 9,
    parameter int ACC_W  = 20,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              win_start,
    input  logic              w_we,
    input  logic [CNT_W-1:0]  w_addr,
    input  logic [W_W-1:0]    w_data,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    output logic              busy,
    output logic              sync_err
);

    typedef enum logic {IDLE, ACC} state_t;

    localparam int PROD_W = DATA_W + W_W + 1;
    localparam logic [CNT_W-1:0] KLAST = CNT_W'(KSIZE - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  acc_out_q, acc_out_d;
    logic                     acc_valid_q, acc_valid_d;
    logic                     sync_err_q, sync_err_d;
    logic signed [W_W-1:0]    weight_q [KSIZE];
    logic signed [W_W-1:0]    weight_d [KSIZE];

    logic [CNT_W-1:0]         sel;
    logic signed [W_W-1:0]    w_sel;
    logic signed [DATA_W:0]   pix_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  result;

    // Element product and running sum. A new window always starts at weight 0.
    // weight_q is read here, so a write in the same cycle only affects later cycles.
    always_comb begin
        sel      = win_start ? '0 : cnt_q;
        w_sel    = weight_q[sel];
        pix_s    = {1'b0, pix_in};
        prod     = PROD_W'(pix_s) * PROD_W'(w_sel);
        prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        sum      = acc_q + prod_ext;
`ifdef CONV_RELU_EN
        result   = sum[ACC_W-1] ? '0 : sum;
`else
        result   = sum;
`endif
    end

    // Kernel weight write port; indices beyond the kernel are ignored.
    always_comb begin
        for (int i = 0; i < KSIZE; i++) begin
            weight_d[i] = weight_q[i];
        end
        if (w_we && (w_addr <= KLAST)) begin
            weight_d[w_addr] = w_data;
        end
    end

    // Next-state logic: window sequencing, result capture and restart detection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = 1'b0;
        sync_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pix_valid && win_start) begin
                    acc_d   = prod_ext;
                    cnt_d   = CNT_W'(1);
                    state_d = ACC;
                end
            end
            ACC: begin
                if (pix_valid) begin
                    if (win_start) begin
                        acc_d      = prod_ext;
                        cnt_d      = CNT_W'(1);
                        sync_err_d = 1'b1;
                    end else if (cnt_q == KLAST) begin
                        acc_out_d   = result;
                        acc_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and weight registers. Reset clears them all, including the weights.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            for (int i = 0; i < KSIZE; i++) begin
                weight_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            sync_err_q  <= sync_err_d;
            for (int i = 0; i < KSIZE; i++) begin
                weight_q[i] <= weight_d[i];
            end
        end
    end

    assign acc_out   = acc_out_q;
    assign acc_valid = acc_valid_q;
    assign sync_err  = sync_err_q;
    assign busy      = (state_q == ACC);

endmodule

// File: tb/tb_conv3x3_mac.sv
// Testbench for conv3x3_mac. The reference model keeps a list of element
// products for the open window and adds them up once nine have arrived.
module tb_conv3x3_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        pix_valid = 1'b0;
    logic        win_start = 1'b0;
    logic        w_we = 1'b0;
    logic [3:0]  w_addr = '0;
    logic [7:0]  w_data = '0;
    logic [19:0] acc_out;
    logic        acc_valid;
    logic        busy;
    logic        sync_err;

    conv3x3_mac dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .win_start (win_start),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .acc_out   (acc_out),
        .acc_valid (acc_valid),
        .busy      (busy),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    int          m_w [9];
    int          m_prods [$];
    bit          m_busy = 1'b0;
    logic [19:0] m_out = '0;
    bit          exp_valid = 1'b0;
    bit          exp_sync = 1'b0;

    int valid_cycles [$];
    int sync_count = 0;
    int pbuf [9];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_w[i] = 0;
        m_prods.delete();
        m_busy = 1'b0;
        m_out = '0;
        exp_valid = 1'b0;
        exp_sync = 1'b0;
    endtask

    // One clock cycle: drive the inputs, advance the model, then compare every output.
    task automatic step(input bit pv, input bit ws, input int pix,
                        input bit we, input int addr, input int wd);
        int s;
        logic [7:0] wb;
        @(negedge clk);
        pix_valid = pv;
        win_start = ws;
        pix_in    = pix[7:0];
        w_we      = we;
        w_addr    = addr[3:0];
        w_data    = wd[7:0];
        @(posedge clk);
        cyc++;
        exp_valid = 1'b0;
        exp_sync  = 1'b0;
        if (pv) begin
            if (ws) begin
                if (m_busy) exp_sync = 1'b1;
                m_prods.delete();
                m_prods.push_back((pix & 255) * m_w[0]);
                m_busy = 1'b1;
            end else if (m_busy) begin
                m_prods.push_back((pix & 255) * m_w[m_prods.size()]);
                if (m_prods.size() == 9) begin
                    s = 0;
                    foreach (m_prods[k]) s += m_prods[k];
`ifdef CONV_RELU_EN
                    if (s < 0) s = 0;
`endif
                    m_out = s[19:0];
                    exp_valid = 1'b1;
                    m_busy = 1'b0;
                    m_prods.delete();
                end
            end
        end
        if (we && addr >= 0 && addr < 9) begin
            wb = wd[7:0];
            m_w[addr] = int'($signed(wb));
        end
        #1;
        if (acc_valid === 1'b1) valid_cycles.push_back(cyc);
        if (sync_err === 1'b1) sync_count++;
        chk("acc_valid", {31'd0, acc_valid}, {31'd0, exp_valid});
        chk("sync_err", {31'd0, sync_err}, {31'd0, exp_sync});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("acc_out", {12'd0, acc_out}, {12'd0, m_out});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_w_all(input int v);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, i, v);
    endtask

    // Feeds pbuf[0..8] as one window, optionally stalling after element stall_after.
    task automatic win9(input int stall_after, input int stall_len);
        for (int i = 0; i < 9; i++) begin
            step(1, i == 0, pbuf[i], 0, 0, 0);
            if (i == stall_after) idle(stall_len);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_acc_out", {12'd0, acc_out}, 32'd0);
        chk("rst_acc_valid", {31'd0, acc_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sync_err", {31'd0, sync_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // all-ones kernel, elements 1..9
        set_w_all(1);
        for (int i = 0; i < 9; i++) pbuf[i] = i + 1;
        valid_cycles.delete();
        win9(-1, 0);
        chk("ones_result", {12'd0, acc_out}, 32'h0002D);
        chk("ones_busy_after", {31'd0, busy}, 32'd0);
        idle(2);
        chk("ones_single_pulse", valid_cycles.size(), 1);

        // all -1 kernel, pixels 255
        set_w_all(-1);
        for (int i = 0; i < 9; i++) pbuf[i] = 255;
        win9(-1, 0);
`ifdef CONV_RELU_EN
        chk("neg_result", {12'd0, acc_out}, 32'h00000);
`else
        chk("neg_result", {12'd0, acc_out}, 32'hFF709);
`endif
        idle(1);

        // positive and negative extremes
        set_w_all(127);
        win9(-1, 0);
        chk("max_pos", {12'd0, acc_out}, 32'h47289);
        set_w_all(-128);
        win9(-1, 0);
`ifdef CONV_RELU_EN
        chk("max_neg", {12'd0, acc_out}, 32'h00000);
`else
        chk("max_neg", {12'd0, acc_out}, 32'hB8480);
`endif

        // ramp kernel, stall of three cycles after element 4
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, i, i + 1);
        for (int i = 0; i < 9; i++) pbuf[i] = 2;
        win9(3, 3);
        chk("stall_result", {12'd0, acc_out}, 32'h0005A);

        // restart after 4 elements
        set_w_all(1);
        valid_cycles.delete();
        sync_count = 0;
        for (int i = 0; i < 4; i++) step(1, i == 0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) pbuf[i] = 1;
        win9(-1, 0);
        idle(2);
        chk("restart_sync_pulses", sync_count, 1);
        chk("restart_valid_pulses", valid_cycles.size(), 1);
        chk("restart_result", {12'd0, acc_out}, 32'd9);

        // two back-to-back windows of random pixels, random weights
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, i, int'($urandom_range(0, 255)));
        valid_cycles.delete();
        for (int i = 0; i < 18; i++) step(1, (i % 9) == 0, int'($urandom_range(0, 255)), 0, 0, 0);
        idle(2);
        chk("b2b_pulses", valid_cycles.size(), 2);
        if (valid_cycles.size() == 2)
            chk("b2b_spacing", valid_cycles[1] - valid_cycles[0], 9);

        // random traffic: stalls, restarts, stray elements, live weight writes
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
                 int'($urandom_range(0, 255)), $urandom_range(0, 4) == 0,
                 int'($urandom_range(0, 11)), int'($urandom_range(0, 255)));
        end
        idle(2);

        // reset in the middle of a window
        set_w_all(3);
        for (int i = 0; i < 5; i++) step(1, i == 0, 200, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("midrst_acc_out", {12'd0, acc_out}, 32'd0);
        chk("midrst_acc_valid", {31'd0, acc_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_sync_err", {31'd0, sync_err}, 32'd0);
        idle(2);
        @(negedge clk);
        rst = 1'b1;
        valid_cycles.delete();
        for (int i = 0; i < 9; i++) pbuf[i] = int'($urandom_range(1, 255));
        win9(-1, 0);
        chk("postrst_result", {12'd0, acc_out}, 32'd0);
        chk("postrst_pulses", valid_cycles.size(), 1);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
